id_stage: RTL and testbench

//  Instruction-decode stage; consumes the 32-bit IF_ID word from the fetch stage, ID_EX register feeds EX.

---
 rtl/id_stage.sv | 207 ++++++++++++++++++++
 tb/tb_id_stage.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage.sv
// rtl/id_stage.sv - instruction decode stage: register file, decoder, load-use hazard, ID_EX register
//
// Optional feature macro: WB_BYPASS_EN
//   defined   : a same-cycle WB write is forwarded to the read ports (write-before-read)
//   undefined : plain register-file read; WB must precede ID by one cycle
module id_stage #(
  parameter int SIZE      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [SIZE-1:0] IF_ID,
  input  logic            if_valid,
  input  logic            ex_ready,
  input  logic            wb_we,
  input  logic [4:0]      wb_addr,
  input  logic [SIZE-1:0] wb_data,
  output logic            id_ready,
  output logic            id_ex_valid,
  output logic [SIZE-1:0] id_ex_rs_data,
  output logic [SIZE-1:0] id_ex_rt_data,
  output logic [SIZE-1:0] id_ex_imm,
  output logic [4:0]      id_ex_rs,
  output logic [4:0]      id_ex_rt,
  output logic [4:0]      id_ex_dst,
  output logic [5:0]      id_ex_funct,
  output logic [3:0]      id_ex_ctrl
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  // ctrl bit positions: {regwrite, memread, memwrite, alusrc}
  localparam int CTRL_MEMREAD = 2;

  // Instruction fields
  logic [5:0] f_op;
  logic [4:0] f_rs;
  logic [4:0] f_rt;
  logic [4:0] f_rd;
  logic [5:0] f_funct;
  logic       unused_shamt;

  assign f_op         = IF_ID[31:26];
  assign f_rs         = IF_ID[25:21];
  assign f_rt         = IF_ID[20:16];
  assign f_rd         = IF_ID[15:11];
  assign f_funct      = IF_ID[5:0];
  assign unused_shamt = ^IF_ID[10:6];

  // Register file storage (r0 is never written, so it always holds 0)
  logic [SIZE-1:0] rf_q [REG_COUNT];

  // Decoder outputs
  logic [3:0]      dec_ctrl;
  logic [4:0]      dec_dst;
  logic            dec_uses_rt;
  logic [SIZE-1:0] dec_imm;

  // Register read values
  logic [SIZE-1:0] rd_rs;
  logic [SIZE-1:0] rd_rt;

  // Hazard
  logic haz;

  // ID_EX pipeline register
  logic            valid_q,   valid_d;
  logic [SIZE-1:0] rs_data_q, rs_data_d;
  logic [SIZE-1:0] rt_data_q, rt_data_d;
  logic [SIZE-1:0] imm_q,     imm_d;
  logic [4:0]      rs_q,      rs_d;
  logic [4:0]      rt_q,      rt_d;
  logic [4:0]      dst_q,     dst_d;
  logic [5:0]      funct_q,   funct_d;
  logic [3:0]      ctrl_q,    ctrl_d;

  // Opcode decode into control bits, destination register and rt usage
  always_comb begin
    dec_ctrl    = 4'b0000;
    dec_dst     = 5'd0;
    dec_uses_rt = 1'b0;
    unique case (f_op)
      OP_RTYPE: begin
        dec_ctrl    = 4'b1000;
        dec_dst     = f_rd;
        dec_uses_rt = 1'b1;
      end
      OP_LW: begin
        dec_ctrl = 4'b1101;
        dec_dst  = f_rt;
      end
      OP_SW: begin
        dec_ctrl    = 4'b0011;
        dec_uses_rt = 1'b1;
      end
      OP_ADDI: begin
        dec_ctrl = 4'b1001;
        dec_dst  = f_rt;
      end
      OP_BEQ: begin
        dec_uses_rt = 1'b1;
      end
      default: begin
        dec_ctrl = 4'b0000;
        dec_dst  = 5'd0;
      end
    endcase
  end

  assign dec_imm = {{(SIZE-16){IF_ID[15]}}, IF_ID[15:0]};

  // Combinational register-file read, r0 hard-wired to zero
  always_comb begin
    rd_rs = (f_rs == 5'd0) ? '0 : rf_q[f_rs];
    rd_rt = (f_rt == 5'd0) ? '0 : rf_q[f_rt];
`ifdef WB_BYPASS_EN
    if (wb_we && (wb_addr == f_rs) && (f_rs != 5'd0)) rd_rs = wb_data;
    if (wb_we && (wb_addr == f_rt) && (f_rt != 5'd0)) rd_rt = wb_data;
`endif
  end

  // Load-use hazard: the load in ID_EX produces a register that IF_ID consumes
  always_comb begin
    haz = if_valid && valid_q && ctrl_q[CTRL_MEMREAD] && (dst_q != 5'd0) &&
          ((dst_q == f_rs) || (dec_uses_rt && (dst_q == f_rt)));
  end

  assign id_ready = ex_ready && !haz;

  // ID_EX next state: hold on backpressure, bubble on hazard, else capture decode
  always_comb begin
    valid_d   = valid_q;
    rs_data_d = rs_data_q;
    rt_data_d = rt_data_q;
    imm_d     = imm_q;
    rs_d      = rs_q;
    rt_d      = rt_q;
    dst_d     = dst_q;
    funct_d   = funct_q;
    ctrl_d    = ctrl_q;
    if (ex_ready) begin
      if (haz) begin
        valid_d = 1'b0;
        ctrl_d  = 4'b0000;
      end else begin
        valid_d   = if_valid;
        rs_data_d = rd_rs;
        rt_data_d = rd_rt;
        imm_d     = dec_imm;
        rs_d      = f_rs;
        rt_d      = f_rt;
        dst_d     = dec_dst;
        funct_d   = f_funct;
        ctrl_d    = if_valid ? dec_ctrl : 4'b0000;
      end
    end
  end

  // ID_EX state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      rs_data_q <= '0;
      rt_data_q <= '0;
      imm_q     <= '0;
      rs_q      <= 5'd0;
      rt_q      <= 5'd0;
      dst_q     <= 5'd0;
      funct_q   <= 6'd0;
      ctrl_q    <= 4'd0;
    end else begin
      valid_q   <= valid_d;
      rs_data_q <= rs_data_d;
      rt_data_q <= rt_data_d;
      imm_q     <= imm_d;
      rs_q      <= rs_d;
      rt_q      <= rt_d;
      dst_q     <= dst_d;
      funct_q   <= funct_d;
      ctrl_q    <= ctrl_d;
    end
  end

  // Register-file write port from WB; writes to r0 are discarded
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_COUNT; i++) rf_q[i] <= '0;
    end else if (wb_we && (wb_addr != 5'd0)) begin
      rf_q[wb_addr] <= wb_data;
    end
  end

  assign id_ex_valid   = valid_q;
  assign id_ex_rs_data = rs_data_q;
  assign id_ex_rt_data = rt_data_q;
  assign id_ex_imm     = imm_q;
  assign id_ex_rs      = rs_q;
  assign id_ex_rt      = rt_q;
  assign id_ex_dst     = dst_q;
  assign id_ex_funct   = funct_q;
  assign id_ex_ctrl    = ctrl_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - randomized self-checking bench for id_stage against a behavioural model
module tb_id_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] IF_ID;
  logic        if_valid;
  logic        ex_ready;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        id_ready;
  logic        id_ex_valid;
  logic [31:0] id_ex_rs_data;
  logic [31:0] id_ex_rt_data;
  logic [31:0] id_ex_imm;
  logic [4:0]  id_ex_rs;
  logic [4:0]  id_ex_rt;
  logic [4:0]  id_ex_dst;
  logic [5:0]  id_ex_funct;
  logic [3:0]  id_ex_ctrl;

  id_stage dut (
    .clk(clk), .rst_n(rst_n), .IF_ID(IF_ID), .if_valid(if_valid), .ex_ready(ex_ready),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .id_ready(id_ready),
    .id_ex_valid(id_ex_valid), .id_ex_rs_data(id_ex_rs_data), .id_ex_rt_data(id_ex_rt_data),
    .id_ex_imm(id_ex_imm), .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_dst(id_ex_dst),
    .id_ex_funct(id_ex_funct), .id_ex_ctrl(id_ex_ctrl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model state
  logic [31:0] m_regs [32];
  logic        m_valid;
  logic [3:0]  m_ctrl;
  logic        m_known;
  logic [31:0] m_rs_data, m_rt_data, m_imm;
  logic [4:0]  m_rs, m_rt, m_dst;
  logic [5:0]  m_funct;
  logic        last_ready;

  // Instruction semantics table: control word, destination, whether rt is a source
  task automatic model_decode(input logic [31:0] ins, output logic [3:0] ctrl,
                              output logic [4:0] dst, output logic urt);
    int op;
    op = int'(ins >> 26);
    ctrl = 4'b0000; dst = 5'd0; urt = 1'b0;
    if (op == 0)       begin ctrl = 4'b1000; dst = 5'((ins >> 11) & 31); urt = 1'b1; end
    else if (op == 35) begin ctrl = 4'b1101; dst = 5'((ins >> 16) & 31); end
    else if (op == 43) begin ctrl = 4'b0011; urt = 1'b1; end
    else if (op == 8)  begin ctrl = 4'b1001; dst = 5'((ins >> 16) & 31); end
    else if (op == 4)  begin urt = 1'b1; end
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a, input logic we,
                                             input logic [4:0] wa, input logic [31:0] wd);
    logic [31:0] v;
    v = (a == 0) ? 32'd0 : m_regs[a];
`ifdef WB_BYPASS_EN
    if (we && wa == a && a != 0) v = wd;
`endif
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_valid = 0; m_ctrl = 0; m_known = 1;
    m_rs_data = 0; m_rt_data = 0; m_imm = 0;
    m_rs = 0; m_rt = 0; m_dst = 0; m_funct = 0;
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".valid"}, 32'(id_ex_valid), 32'(m_valid));
    check({tag, ".ctrl"}, 32'(id_ex_ctrl), 32'(m_ctrl));
    if (m_known) begin
      check({tag, ".rs_data"}, id_ex_rs_data, m_rs_data);
      check({tag, ".rt_data"}, id_ex_rt_data, m_rt_data);
      check({tag, ".imm"}, id_ex_imm, m_imm);
      check({tag, ".fields"}, {12'd0, id_ex_rs, id_ex_rt, id_ex_dst, id_ex_funct},
            {12'd0, m_rs, m_rt, m_dst, m_funct});
    end
  endtask

  // One clock: drive at negedge, check id_ready, advance model at posedge, check ID_EX
  task automatic step(input string tag, input logic [31:0] ins, input logic v, input logic er,
                      input logic we, input logic [4:0] wa, input logic [31:0] wd);
    logic [3:0] ctrl;
    logic [4:0] dst, rs, rt;
    logic urt, haz;
    @(negedge clk);
    IF_ID = ins; if_valid = v; ex_ready = er; wb_we = we; wb_addr = wa; wb_data = wd;
    #1;
    model_decode(ins, ctrl, dst, urt);
    rs = 5'((ins >> 21) & 31);
    rt = 5'((ins >> 16) & 31);
    haz = v && m_valid && m_ctrl[2] && m_dst != 0 && (m_dst == rs || (urt && m_dst == rt));
    last_ready = id_ready;
    check({tag, ".id_ready"}, 32'(id_ready), 32'(er && !haz));
    @(posedge clk);
    if (er) begin
      if (haz) begin
        m_valid = 0; m_ctrl = 0; m_known = 0;
      end else begin
        m_valid = v; m_ctrl = v ? ctrl : 4'b0000; m_known = 1;
        m_rs_data = model_read(rs, we, wa, wd);
        m_rt_data = model_read(rt, we, wa, wd);
        m_imm = (ins & 32'h8000) != 0 ? (ins | 32'hFFFF0000) : (ins & 32'h0000FFFF);
        m_rs = rs; m_rt = rt; m_dst = dst; m_funct = 6'(ins & 63);
      end
    end
    if (we && wa != 0) m_regs[wa] = wd;
    #1;
    check_outputs(tag);
  endtask

  function automatic logic [31:0] rand_instr();
    int ops [6] = '{0, 35, 43, 8, 4, 13};
    logic [31:0] op, rs, rt, lo;
    op = 32'(ops[$urandom_range(0, 5)]);
    rs = 32'($urandom_range(0, 7));
    rt = 32'($urandom_range(0, 7));
    lo = 32'($urandom) & 32'hFFFF;
    if ($urandom_range(0, 1) == 1) lo = (lo & 32'h07FF) | (32'($urandom_range(0, 7)) << 11);
    return (op << 26) | (rs << 21) | (rt << 16) | lo;
  endfunction

  localparam logic [31:0] LW_R9  = {6'b100011, 5'd1, 5'd9, 16'd4};
  localparam logic [31:0] ADD_R10 = {6'b000000, 5'd9, 5'd2, 5'd10, 5'd0, 6'b100000};
  localparam logic [31:0] ADDI_M1 = {6'b001000, 5'd0, 5'd9, 16'hFFFF};
  localparam logic [31:0] RT_EX  = 32'b000000_00100_01000_10000_00000_010000;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] snap;
    model_reset();
    rst_n = 0; IF_ID = 0; if_valid = 0; ex_ready = 1; wb_we = 0; wb_addr = 0; wb_data = 0;
    #12;
    check("reset.valid", 32'(id_ex_valid), 32'd0);
    check("reset.id_ready", 32'(id_ready), 32'd1);
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1;

    // r0 is never written
    step("r0w", 32'd0, 0, 1, 1, 5'd0, 32'hDEAD);
    step("r0r", {6'b0, 5'd0, 5'd0, 5'd3, 5'd0, 6'd32}, 1, 1, 0, 0, 0);
    check("r0.rs_data", id_ex_rs_data, 32'd0);

    // R-type example
    step("w4", 32'd0, 0, 1, 1, 5'd4, 32'd3);
    step("w8", 32'd0, 0, 1, 1, 5'd8, 32'd5);
    step("rtype", RT_EX, 1, 1, 0, 0, 0);
    check("rtype.const", {id_ex_rs_data[7:0], id_ex_rt_data[7:0], 3'd0, id_ex_dst,
          2'd0, id_ex_funct}, {8'd3, 8'd5, 3'd0, 5'd16, 2'd0, 6'b010000});
    check("rtype.ctrl", {27'd0, id_ex_valid, id_ex_ctrl}, {27'd0, 1'b1, 4'b1000});

    // Load-use: one stall, one bubble, then issue
    step("lu.lw", LW_R9, 1, 1, 0, 0, 0);
    step("lu.stall", ADD_R10, 1, 1, 0, 0, 0);
    check("lu.ready0", 32'(last_ready), 32'd0);
    check("lu.bubble", {27'd0, id_ex_valid, id_ex_ctrl}, 32'd0);
    step("lu.add", ADD_R10, 1, 1, 0, 0, 0);
    check("lu.ready1", 32'(last_ready), 32'd1);
    check("lu.issued", {27'd0, id_ex_dst}, 32'd10);

    // No false hazard through an unused rt field
    step("nf.lw", LW_R9, 1, 1, 0, 0, 0);
    step("nf.addi", ADDI_M1, 1, 1, 0, 0, 0);
    check("nf.ready", 32'(last_ready), 32'd1);
    check("nf.imm", id_ex_imm, 32'hFFFFFFFF);

    // Backpressure for three cycles
    step("bp.load", RT_EX, 1, 1, 0, 0, 0);
    snap = id_ex_rs_data;
    for (int i = 0; i < 3; i++) begin
      step("bp.hold", rand_instr(), 1, 0, 0, 0, 0);
      check("bp.ready", 32'(last_ready), 32'd0);
    end
    check("bp.data", id_ex_rs_data, snap);
    step("bp.release", ADD_R10, 1, 1, 0, 0, 0);

    // Same-cycle WB write and read
    step("sc.w", 32'd0, 0, 1, 1, 5'd7, 32'h11);
    step("sc.rw", {6'b0, 5'd7, 5'd0, 5'd1, 5'd0, 6'd32}, 1, 1, 1, 5'd7, 32'h55);
`ifdef WB_BYPASS_EN
    check("sc.new", id_ex_rs_data, 32'h55);
`else
    check("sc.old", id_ex_rs_data, 32'h11);
`endif

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      step("rnd", rand_instr(), $urandom_range(0, 99) < 85, $urandom_range(0, 99) < 75,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
    end

    // Reset mid-run with a valid instruction held in ID_EX
    step("mr.w5", 32'd0, 0, 1, 1, 5'd5, 32'h1234);
    step("mr.load", LW_R9, 1, 1, 0, 0, 0);
    check("mr.pre", 32'(id_ex_valid), 32'd1);
    #2;
    rst_n = 0;
    ex_ready = 1;
    #1;
    model_reset();
    check("mr.valid", 32'(id_ex_valid), 32'd0);
    check("mr.id_ready", 32'(id_ready), 32'd1);
    check_outputs("mr");
    @(negedge clk);
    rst_n = 1;
    step("mr.r5", {6'b0, 5'd5, 5'd5, 5'd2, 5'd0, 6'd32}, 1, 1, 0, 0, 0);
    check("mr.r5data", id_ex_rs_data, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
